// File: rtl/return_stack_pkg.sv
// Shared CPU return-stack definitions: stack depth, return-address width and op decode.
// Pure declarations; no latency or flow control.
package return_stack_pkg;

  localparam int STACK_DEPTH      = 8;
  localparam int STACK_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/return_stack_stack_mem.sv
// Return-stack storage: register array, write on the rising edge, read combinationally.
// Write lands one edge after sampling; no backpressure.
module stack_mem
  import return_stack_pkg::*;
#(
  parameter int DataWidth = STACK_DATA_WIDTH,
  parameter int Depth     = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [DataWidth-1:0]     wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [DataWidth-1:0]     rdata
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Subroutine return-address stack: counter, sticky error flags and top-of-stack select.
// Every operation is visible one Clk edge later; refused push/pop only raises a sticky flag.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DataWidth = STACK_DATA_WIDTH,
  parameter int Depth     = STACK_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic [DataWidth-1:0]   DIn,
  output logic [DataWidth-1:0]   DOut,
  output logic                   Empty,
  output logic                   Full,
  output logic [$clog2(Depth):0] Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = count_width(Depth);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(Depth);

  logic [CW-1:0]        count_q;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 is_empty;
  logic                 is_full;
  logic [AW-1:0]        top_idx;
  logic [DataWidth-1:0] top_dat;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  stack_op_e            op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_CNT);
  // When full, the low bits wrap to 0 so top_idx still lands on Depth-1.
  assign top_idx  = count_q[AW-1:0] - AW'(1);

  // Push+pop on an empty stack degenerates to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (Push && Pop && !is_empty) begin
      op = OP_REPLACE;
    end else if (Push) begin
      op = OP_PUSH;
    end else if (Pop) begin
      op = OP_POP;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = count_q[AW-1:0];
    case (op)
      OP_PUSH: begin
        mem_we = !is_full;
      end
      OP_REPLACE: begin
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
      default: begin
      end
    endcase
    if (Reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf_q <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf_q <= 1'b1;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  stack_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_stack_mem (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (DIn),
    .raddr (top_idx),
    .rdata (top_dat)
  );

  // Stale entries above Count never reach DOut.
  assign DOut      = is_empty ? '0 : top_dat;
  assign Empty     = is_empty;
  assign Full      = is_full;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Scoreboarded bench for return_stack: directed scenarios then random push/pop/reset traffic.
module tb_return_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          Clk;
  logic          Reset;
  logic          Push;
  logic          Pop;
  logic [DW-1:0] DIn;
  logic [DW-1:0] DOut;
  logic          Empty;
  logic          Full;
  logic [3:0]    Count;
  logic          Overflow;
  logic          Underflow;

  return_stack #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Push      (Push),
    .Pop       (Pop),
    .DIn       (DIn),
    .DOut      (DOut),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         count;
    logic [15:0] dout;
    bit         empty;
    bit         full;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model[$];
  bit          m_ovf;
  bit          m_unf;
  int          total_cnt;
  int          pass_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: a plain queue used as a stack, following the behavioural rules directly.
  task automatic model_step(input bit rst, input bit psh, input bit pp, input logic [15:0] d);
    exp_t e;
    if (rst) begin
      model.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (psh && pp) begin
      if (model.size() == 0) model.push_back(d);
      else model[model.size()-1] = d;
    end else if (psh) begin
      if (model.size() == DEPTH) m_ovf = 1;
      else model.push_back(d);
    end else if (pp) begin
      if (model.size() == 0) m_unf = 1;
      else void'(model.pop_back());
    end
    e.count = model.size();
    e.dout  = (model.size() == 0) ? 16'h0 : model[model.size()-1];
    e.empty = (model.size() == 0);
    e.full  = (model.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic do_op(input bit rst, input bit psh, input bit pp, input logic [15:0] d);
    @(negedge Clk);
    Reset = rst;
    Push  = psh;
    Pop   = pp;
    DIn   = d;
    model_step(rst, psh, pp, d);
  endtask

  // Monitor: outputs are checked #1 after each edge against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count",     32'(Count),     32'(e.count));
        check("dout",      32'(DOut),      32'(e.dout));
        check("empty",     32'(Empty),     32'(e.empty));
        check("full",      32'(Full),      32'(e.full));
        check("overflow",  32'(Overflow),  32'(e.ovf));
        check("underflow", 32'(Underflow), 32'(e.unf));
      end
    end
  end

  initial begin
    int bias;
    Reset = 1'b0;
    Push  = 1'b0;
    Pop   = 1'b0;
    DIn   = '0;
    total_cnt = 0;
    pass_cnt  = 0;

    // Reset, three pushes, three pops, pop-when-empty, push after underflow.
    do_op(1, 0, 0, 16'h0);
    do_op(0, 1, 0, 16'h0010);
    do_op(0, 1, 0, 16'h0020);
    do_op(0, 1, 0, 16'h0030);
    do_op(0, 0, 1, 16'h0);
    do_op(0, 0, 1, 16'h0);
    do_op(0, 0, 1, 16'h0);
    do_op(0, 0, 1, 16'h0);
    do_op(0, 1, 0, 16'h1234);
    do_op(0, 0, 0, 16'h0);

    // Nine distinct pushes into an eight-entry stack.
    do_op(1, 0, 0, 16'h0);
    for (int i = 1; i <= 9; i++) do_op(0, 1, 0, 16'(16'h0100 + i));
    do_op(0, 0, 0, 16'h0);

    // Replace on a two-deep stack, then push+pop on empty.
    do_op(1, 0, 0, 16'h0);
    do_op(0, 1, 0, 16'h0030);
    do_op(0, 1, 0, 16'h0040);
    do_op(0, 1, 1, 16'h0055);
    do_op(0, 0, 1, 16'h0);
    do_op(0, 0, 1, 16'h0);
    do_op(0, 1, 1, 16'h0066);

    // Replace while full, then reset with Count=5, Push high and Overflow set.
    do_op(1, 0, 0, 16'h0);
    for (int i = 0; i < 9; i++) do_op(0, 1, 0, 16'(16'h0A00 + i));
    do_op(0, 1, 1, 16'hBEEF);
    for (int i = 0; i < 3; i++) do_op(0, 0, 1, 16'h0);
    do_op(1, 1, 0, 16'hDEAD);
    do_op(0, 0, 0, 16'h0);

    // Random traffic; push/pop bias shifts to drive the stack to both ends.
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      bit r, p, q;
      if (i % 100 == 0) bias = $urandom_range(15, 85);
      r = ($urandom_range(0, 99) == 0);
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) >= bias);
      if ($urandom_range(0, 9) == 0) begin
        p = 1;
        q = 1;
      end
      do_op(r, p, q, 16'($urandom_range(0, 16'hFFFF)));
    end

    @(negedge Clk);
    Reset = 1'b0;
    Push  = 1'b0;
    Pop   = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DataWidth, 16, width of each stored return address.
REQ-002 Parameter Depth, 8, number of stack entries; power of two, at least 2.
REQ-003 Port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1, synchronous, active-high reset.
REQ-005 Port Push, input, 1, push DIn; driven by the sequence controller's STK_Ld.
REQ-006 Port Pop, input, 1, pop the top entry; asserted by the sequence controller on return.
REQ-007 Port DIn, input, DataWidth, return address to push (PC + WordByteSize from the program counter).
REQ-008 Port DOut, output, DataWidth, current top-of-stack; feeds the PC source mux.
REQ-009 Port Empty, output, 1, high when entry count is 0.
REQ-010 Port Full, output, 1, high when entry count equals Depth.
REQ-011 Port Count, output, clog2(Depth)+1, current number of entries.
REQ-012 Port Overflow, output, 1, sticky error flag: push refused because the stack was full.
REQ-013 Port Underflow, output, 1, sticky error flag: pop refused because the stack was empty.

Function
REQ-014 All outputs are registered or decoded from registered state only; no combinational path from Push, Pop or DIn to any output.
REQ-015 Push alone, not full: write DIn at index Count, increment Count by 1; DOut equals DIn from the next cycle.
REQ-016 Pop alone, not empty: decrement Count by 1; DOut shows the entry below the old top from the next cycle.
REQ-017 DOut reads 0 whenever Empty is high.
REQ-018 Push and Pop together, not empty: replace the top entry with DIn; Count unchanged; no flag change. This includes the full case.
REQ-019 Push and Pop together, empty: behave as push alone (Count becomes 1); Underflow not set.
REQ-020 Push alone when full: no storage or Count change; Overflow set.
REQ-021 Pop alone when empty: no storage or Count change; DOut stays 0; Underflow set.
REQ-022 Overflow and Underflow stay set until Reset; no other event clears them.
REQ-023 Count never wraps: it saturates at 0 and at Depth.
REQ-024 Entries not covered by Count are don't-care and are never visible on DOut.
REQ-025 Latency: any operation is visible on all outputs exactly one Clk edge after it is sampled.

Reset
REQ-026 While Reset is high at a Clk edge, the edge clears state: Count=0, Empty=1, Full=0, DOut=0, Overflow=0, Underflow=0.
REQ-027 Reset overrides Push and Pop sampled on the same edge, including when asserted mid-sequence with entries stored.
REQ-028 Storage array contents need no reset.

Structure
REQ-029 Stack depth and address-width constants for the CPU live in the shared definitions include used by the control and PC modules.
REQ-030 Storage is one sub-module, stack_mem: a register array with synchronous write and asynchronous read.
REQ-031 return_stack contains only the counter, flag logic and top-of-stack selection.
REQ-032 Target size is 120-400 lines of RTL in total.

Verification
REQ-033 Reset, then push 0x0010, 0x0020, 0x0030 on consecutive cycles -> Count=3, DOut=0x0030, Empty=0, Full=0.
REQ-034 Pop three times from that state -> DOut sequence 0x0020, 0x0010, 0; Count=0, Empty=1, Underflow=0.
REQ-035 Push 9 distinct values with Depth=8 -> Full=1 after the 8th push, Overflow=1 after the 9th, DOut equals the 8th value.
REQ-036 Pop when empty -> Underflow=1, Count=0, DOut=0; a following push of 0x1234 gives Count=1, DOut=0x1234, Underflow still 1.
REQ-037 Push and Pop together with top=0x0040 and Count=2 -> DOut=DIn, Count=2; same on an empty stack -> Count=1.
REQ-038 Assert Reset with Count=5, Push=1 and Overflow=1 -> next edge gives Count=0, Empty=1, DOut=0, both flags 0.
